// File: rtl/usr_pkg.sv
// Shared definitions for the universal-shift-register serial link:
// mode-select encoding, receiver FSM states and shift direction.
package usr_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_CLR  = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } state_t;

    typedef enum logic {
        DIR_RIGHT,
        DIR_LEFT
    } dir_t;

    function automatic logic is_shift(input logic [1:0] sel);
        return (sel == SEL_SHR) || (sel == SEL_SHL);
    endfunction

endpackage

// File: rtl/usr_bit_counter.sv
// Mod-WIDTH bit counter for the deserializer: sync clear, load-to-1,
// increment with wrap, and a terminal-count flag at WIDTH-1.
module usr_bit_counter #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_one,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    assign tc = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load_one) begin
            cnt <= CNT_W'(1);
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/usr_deserializer.sv
// Receive end of the universal-shift-register link: assembles WIDTH-bit
// words from a serial stream and hands them out through a valid/ready buffer.
module usr_deserializer
    import usr_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sel,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             frame_err,
    output logic             overrun
);

    state_t           state, state_next;
    dir_t             dir, sel_dir;
    logic [WIDTH-1:0] shreg, shifted, base;
    logic             accept, tc;
    logic             cnt_clear, cnt_load1, cnt_inc;
    logic             mismatch, complete;

    function automatic logic [WIDTH-1:0] shift_bit(input logic [WIDTH-1:0] w,
                                                   input dir_t d, input logic b);
        return (d == DIR_LEFT) ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
    endfunction

    assign accept  = sin_valid && is_shift(sel);
    assign sel_dir = (sel == SEL_SHL) ? DIR_LEFT : DIR_RIGHT;

    // A fresh word (from IDLE or after a direction change) starts from zero.
    assign base    = (state == ST_RECV && !mismatch) ? shreg : '0;
    assign shifted = shift_bit(base, sel_dir, sin);

    usr_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .load_one (cnt_load1),
        .inc      (cnt_inc),
        .cnt      (bit_cnt),
        .tc       (tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_load1  = 1'b0;
        cnt_inc    = 1'b0;
        mismatch   = 1'b0;
        complete   = 1'b0;
        if (sel == SEL_CLR) begin
            state_next = ST_IDLE;
            cnt_clear  = 1'b1;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    cnt_load1  = 1'b1;
                    state_next = ST_RECV;
                end
                ST_RECV: begin
                    if (sel_dir != dir) begin
                        mismatch  = 1'b1;
                        cnt_load1 = 1'b1;
                    end else if (tc) begin
                        complete   = 1'b1;
                        cnt_inc    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg     <= '0;
            dir       <= DIR_RIGHT;
            out       <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= mismatch;
            if (sel == SEL_CLR) begin
                shreg   <= '0;
                overrun <= 1'b0;
            end else if (accept) begin
                shreg <= shifted;
                dir   <= sel_dir;
            end
            // A buffered word that is being consumed this edge frees the slot.
            if (complete) begin
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end else begin
                    out       <= shifted;
                    out_valid <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
